pixel_proc_pipe: RTL and testbench
==================================

// Module: pixel_proc_pipe
// PURPOSE
//  Streaming RGB point-operation engine. Parametrised channel width, valid/ready
//  handshake with backpressure, 2-stage pipeline, frame-synchronous config latch.
//  Sits between the pixel source (line reader) and the downstream writer/encoder.
// PARAMETERS
//  CW       8   bits per colour channel; pixel is 3*CW bits, {R,G,B}, R in the MSBs
//  OPW      3   width of the operation-select field
// PORTS
//  clk          in   1      clock, all logic on rising edge
//  rst          in   1      synchronous reset, active-high
//  s_valid      in   1      input beat valid
//  s_ready      out  1      input beat accepted when s_valid && s_ready
//  s_pixel      in   3*CW   input pixel {R,G,B}
//  s_sof        in   1      beat is first pixel of a frame
//  m_valid      out  1      output beat valid
//  m_ready      in   1      downstream ready
//  m_pixel      out  3*CW   processed pixel
//  m_sof        out  1      start-of-frame flag, delayed with its pixel
//  cfg_op       in   OPW    requested operation (see BEHAVIOUR)
//  cfg_thresh   in   CW     threshold level, unsigned
//  cfg_bright   in   CW     brightness offset, two's complement signed
//  clamp_cnt    out  32     [PIXPROC_CLAMP_CNT_EN only] saturations in current frame
// BEHAVIOUR
//  - Reset: m_valid=0, m_pixel=0, m_sof=0, both stage valids=0. Shadow config
//    goes to op=passthrough, thresh=0, bright=0. clamp_cnt=0.
//  - Advance enable en = !m_valid || m_ready. s_ready = en. This is combinational
//    from m_ready; no other comb path from input to output.
//  - Stage 1 (on en): capture pixel, sof, valid = s_valid, and the active shadow config.
//    Stage 2 (on en): compute result; m_* update from stage 1.
//  - Latency is exactly 2 clk from acceptance to m_valid when m_ready stays high.
//    Throughput is 1 pixel/clk.
//  - Stall (m_valid && !m_ready): all stages hold and m_pixel/m_sof stay stable.
//    No beat is lost or duplicated. Bubbles (s_valid=0) propagate as invalid slots.
//  - Config shadow: cfg_* is sampled into the shadow only on an accepted beat with
//    s_sof=1. That beat and every later beat use the new config. cfg changes
//    mid-frame have no effect until the next sof.
//  - Ops on shadow op:
//    - 0 passthrough.
//    - 1 invert: each channel bitwise NOT.
//    - 2 threshold: ch > thresh ? all-ones : 0.
//    - 3 brightness: ch + sign_ext(bright), computed in CW+2 signed bits,
//      clamped to [0, 2^CW-1].
//    - 4 grayscale: y = (77R+150G+29B) >> 8 in CW+8 bits; output {y,y,y}.
//    - 5..7 are reserved and behave as passthrough.
//  - Boundaries:
//    - bright=+max on a full-scale channel saturates high.
//    - bright=-2^(CW-1) on 0 saturates at 0.
//    - thresh=all-ones makes every channel 0.
//    - Grayscale of all-ones gives 2^CW-1-? : exact value is floor(256*(2^CW-1)/256)=2^CW-1.
//    - rst asserted mid-stall or mid-frame clears the pipeline; in-flight beats are dropped.
// CONFIGURATION
//  PIXPROC_CLAMP_CNT_EN defined:
//    - clamp_cnt counts the channels saturated by the brightness op on each output
//      beat (0..3 added per m_valid&&m_ready transfer).
//    - It clears to 0 at the transfer of an m_sof beat, then adds that beat's count.
//    - It saturates at 2^32-1 and does not wrap.
//  PIXPROC_CLAMP_CNT_EN undefined: the port and the counter are absent; the
//    datapath is identical in both builds.
// STRUCTURE
//  pixproc_pkg:
//    - localparams OP_PASS, OP_INV, OP_THR, OP_BRT, OP_GRAY.
//    - Grayscale weights W_R=77, W_G=150, W_B=29 and GRAY_SHIFT=8.
//  Sub-module pixproc_chan_alu: one instance per channel, combinational.
//    - Inputs: ch, op, thresh, bright. Outputs: result, sat.
//    - Grayscale is computed in the top level because it needs all three channels.
// TESTING
//  1 op=1 with sof, pixel 0x123456, m_ready=1 -> 0xEDCBA9 exactly 2 clk after accept.
//  2 op=3, bright=0x14, pixels 0xF0_10_80 then bright=0xEC (-20) on next sof, pixel
//    0x0A_FF_80 -> 0xFF_24_94 then 0x00_EB_6C; clamp_cnt=1 after each frame's beat.
//  3 op=2, thresh=0x80, pixel 0x80_81_00 -> 0x00_FF_00; op=4, pixel 0xFF_FF_FF
//    -> 0xFF_FF_FF, pixel 0x646464 -> 0x646464.
//  4 Stream 16 pixels with random m_ready and s_valid gaps -> output order and count
//    match the model, m_pixel stable while stalled.
//  5 Change cfg_op mid-frame 1->0 -> no effect until next sof beat, which is passthrough.
//  6 Assert rst for 1 clk during a stall with 2 beats in flight -> m_valid=0 next clk,
//    and shadow op reads back as passthrough.

Source files
------------

// File: rtl/pixproc_pkg.sv
// Shared constants for the pixel point-operation pipeline: operation codes
// and the grayscale luma weights.
package pixproc_pkg;

    // Operation-select encodings; codes above OP_GRAY are reserved (passthrough)
    localparam int unsigned OP_PASS = 0;
    localparam int unsigned OP_INV  = 1;
    localparam int unsigned OP_THR  = 2;
    localparam int unsigned OP_BRT  = 3;
    localparam int unsigned OP_GRAY = 4;

    // Grayscale weights: y = (W_R*R + W_G*G + W_B*B) >> GRAY_SHIFT
    localparam int unsigned W_R        = 77;
    localparam int unsigned W_G        = 150;
    localparam int unsigned W_B        = 29;
    localparam int unsigned GRAY_SHIFT = 8;

endpackage

// File: rtl/pixproc_chan_alu.sv
// Per-channel combinational point operation: passthrough, invert, threshold
// and signed brightness offset with clamping. Grayscale needs all three
// channels and is handled by the parent; here it falls through as passthrough.
module pixproc_chan_alu
    import pixproc_pkg::*;
#(
    parameter int unsigned CW  = 8,
    parameter int unsigned OPW = 3
) (
    input  logic [CW-1:0]  ch,
    input  logic [OPW-1:0] op,
    input  logic [CW-1:0]  thresh,
    input  logic [CW-1:0]  bright,
    output logic [CW-1:0]  result,
    output logic           sat
);

    // Two guard bits hold both the sign and the overflow of ch + bright
    logic signed [CW+1:0] sum;

    // Select the channel result for the requested operation
    always_comb begin
        sum    = $signed({2'b00, ch}) + $signed({{2{bright[CW-1]}}, bright});
        result = ch;
        sat    = 1'b0;
        case (op)
            OPW'(OP_INV): result = ~ch;
            OPW'(OP_THR): result = (ch > thresh) ? '1 : '0;
            OPW'(OP_BRT): begin
                if (sum[CW+1]) begin
                    result = '0;
                    sat    = 1'b1;
                end else if (sum[CW]) begin
                    result = '1;
                    sat    = 1'b1;
                end else begin
                    result = sum[CW-1:0];
                end
            end
            default: result = ch;
        endcase
    end

endmodule

// File: rtl/pixel_proc_pipe.sv
// Streaming RGB point-operation engine: valid/ready handshake, two-stage
// pipeline, configuration latched into a shadow on each start-of-frame beat.
// Optional feature macro: PIXPROC_CLAMP_CNT_EN adds the clamp_cnt port, a
// per-frame count of channels saturated by the brightness operation.
module pixel_proc_pipe
    import pixproc_pkg::*;
#(
    parameter int unsigned CW  = 8,
    parameter int unsigned OPW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [3*CW-1:0]   s_pixel,
    input  logic              s_sof,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [3*CW-1:0]   m_pixel,
    output logic              m_sof,
    input  logic [OPW-1:0]    cfg_op,
    input  logic [CW-1:0]     cfg_thresh,
    input  logic [CW-1:0]     cfg_bright
`ifdef PIXPROC_CLAMP_CNT_EN
    ,
    output logic [31:0]       clamp_cnt
`endif
);

    logic              en;
    logic              take_cfg;

    logic [OPW-1:0]    sh_op;
    logic [CW-1:0]     sh_thresh;
    logic [CW-1:0]     sh_bright;

    logic [OPW-1:0]    act_op;
    logic [CW-1:0]     act_thresh;
    logic [CW-1:0]     act_bright;

    logic              s1_valid;
    logic [3*CW-1:0]   s1_pixel;
    logic              s1_sof;
    logic [OPW-1:0]    s1_op;
    logic [CW-1:0]     s1_thresh;
    logic [CW-1:0]     s1_bright;

    logic [CW-1:0]     alu_res [3];
    logic [CW+7:0]     gray_sum;
    logic [CW-1:0]     gray_y;
    logic [3*CW-1:0]   res_pixel;

    // The whole pipe advances together whenever the output slot can move
    always_comb begin
        en       = !m_valid || m_ready;
        s_ready  = en;
        take_cfg = s_valid && en && s_sof;
    end

    // A start-of-frame beat uses the incoming config; all others use the shadow
    always_comb begin
        act_op     = sh_op;
        act_thresh = sh_thresh;
        act_bright = sh_bright;
        if (take_cfg) begin
            act_op     = cfg_op;
            act_thresh = cfg_thresh;
            act_bright = cfg_bright;
        end
    end

    // Shadow config register, reloaded only on accepted start-of-frame beats
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_op     <= OPW'(OP_PASS);
            sh_thresh <= '0;
            sh_bright <= '0;
        end else if (take_cfg) begin
            sh_op     <= cfg_op;
            sh_thresh <= cfg_thresh;
            sh_bright <= cfg_bright;
        end
    end

    // Stage 1: capture the beat together with the config it must be processed with
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_pixel  <= '0;
            s1_sof    <= 1'b0;
            s1_op     <= OPW'(OP_PASS);
            s1_thresh <= '0;
            s1_bright <= '0;
        end else if (en) begin
            s1_valid  <= s_valid;
            s1_pixel  <= s_pixel;
            s1_sof    <= s_valid && s_sof;
            s1_op     <= act_op;
            s1_thresh <= act_thresh;
            s1_bright <= act_bright;
        end
    end

`ifdef PIXPROC_CLAMP_CNT_EN
    logic [2:0]        sat_vec;
`endif

    // One ALU per channel; index 0 is blue (LSBs), index 2 is red (MSBs)
    for (genvar i = 0; i < 3; i++) begin : g_chan
        pixproc_chan_alu #(
            .CW  (CW),
            .OPW (OPW)
        ) u_alu (
            .ch     (s1_pixel[i*CW +: CW]),
            .op     (s1_op),
            .thresh (s1_thresh),
            .bright (s1_bright),
            .result (alu_res[i]),
`ifdef PIXPROC_CLAMP_CNT_EN
            .sat    (sat_vec[i])
`else
            .sat    ()
`endif
        );
    end

    // Luma needs all three channels, so it is formed here and overrides the ALUs
    always_comb begin
        gray_sum = (CW+8)'(W_R) * (CW+8)'(s1_pixel[2*CW +: CW])
                 + (CW+8)'(W_G) * (CW+8)'(s1_pixel[CW +: CW])
                 + (CW+8)'(W_B) * (CW+8)'(s1_pixel[0 +: CW]);
        gray_y   = CW'(gray_sum >> GRAY_SHIFT);
        if (s1_op == OPW'(OP_GRAY)) begin
            res_pixel = {gray_y, gray_y, gray_y};
        end else begin
            res_pixel = {alu_res[2], alu_res[1], alu_res[0]};
        end
    end

    // Stage 2: output register, held while the downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_pixel <= '0;
            m_sof   <= 1'b0;
        end else if (en) begin
            m_valid <= s1_valid;
            m_pixel <= res_pixel;
            m_sof   <= s1_sof;
        end
    end

`ifdef PIXPROC_CLAMP_CNT_EN
    logic [1:0]        sat_cnt;
    logic [1:0]        m_sat_cnt;
    logic [32:0]       clamp_sum;
    logic [31:0]       clamp_next;

    // Saturated channels of this beat, and the saturating per-frame accumulation
    always_comb begin
        sat_cnt    = 2'(sat_vec[0]) + 2'(sat_vec[1]) + 2'(sat_vec[2]);
        clamp_sum  = {1'b0, clamp_cnt} + 33'(m_sat_cnt);
        clamp_next = clamp_sum[32] ? '1 : clamp_sum[31:0];
        if (m_sof) begin
            clamp_next = 32'(m_sat_cnt);
        end
    end

    // Saturation count travels with its beat through the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            m_sat_cnt <= '0;
        end else if (en) begin
            m_sat_cnt <= s1_valid ? sat_cnt : 2'd0;
        end
    end

    // Frame clamp counter, updated on each output transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            clamp_cnt <= '0;
        end else if (m_valid && m_ready) begin
            clamp_cnt <= clamp_next;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_proc_pipe.sv
// Self-checking bench for pixel_proc_pipe (CW=8). Expected pixels come from
// an integer reference model of the point operations; clamp_cnt checks are
// compiled only when PIXPROC_CLAMP_CNT_EN is defined.
module tb_pixel_proc_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_pixel;
    logic        s_sof;
    logic        m_valid;
    logic        m_ready;
    logic [23:0] m_pixel;
    logic        m_sof;
    logic [2:0]  cfg_op;
    logic [7:0]  cfg_thresh;
    logic [7:0]  cfg_bright;
`ifdef PIXPROC_CLAMP_CNT_EN
    logic [31:0] clamp_cnt;
`endif

    always #5 clk = ~clk;

    pixel_proc_pipe #(
        .CW  (8),
        .OPW (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_pixel    (s_pixel),
        .s_sof      (s_sof),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_pixel    (m_pixel),
        .m_sof      (m_sof),
        .cfg_op     (cfg_op),
        .cfg_thresh (cfg_thresh),
        .cfg_bright (cfg_bright)
`ifdef PIXPROC_CLAMP_CNT_EN
        ,
        .clamp_cnt  (clamp_cnt)
`endif
    );

    typedef struct {
        logic [23:0] pix;
        logic        sof;
        int          sat;
    } exp_t;

    exp_t   exp_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     mdl_op, mdl_thr, mdl_bri;
    longint mdl_clamp;

    // Reference: the point operations in plain integer arithmetic
    function automatic exp_t ref_beat(input logic [23:0] p, input logic sof,
                                      input int op, input int thr, input int bri);
        exp_t e;
        int   c[3];
        int   y;
        int   v;
        e.sat = 0;
        e.sof = sof;
        c[0] = int'(p[23:16]);
        c[1] = int'(p[15:8]);
        c[2] = int'(p[7:0]);
        if (op == 4) begin
            y = (77 * c[0] + 150 * c[1] + 29 * c[2]) / 256;
            for (int i = 0; i < 3; i++) c[i] = y;
        end else begin
            for (int i = 0; i < 3; i++) begin
                case (op)
                    1: c[i] = 255 - c[i];
                    2: c[i] = (c[i] > thr) ? 255 : 0;
                    3: begin
                        v = c[i] + bri;
                        if (v < 0) begin
                            v = 0;
                            e.sat++;
                        end else if (v > 255) begin
                            v = 255;
                            e.sat++;
                        end
                        c[i] = v;
                    end
                    default: ;
                endcase
            end
        end
        e.pix = {c[0][7:0], c[1][7:0], c[2][7:0]};
        return e;
    endfunction

    // Drive one cycle of inputs and return what was observed mid-cycle
    task automatic step(input logic sv, input logic [23:0] pix, input logic sof,
                        input logic mr, output logic acc, output logic mv,
                        output logic [23:0] mp, output logic ms);
        longint t;
        s_valid = sv;
        s_pixel = pix;
        s_sof   = sof;
        m_ready = mr;
        @(negedge clk);
        acc = s_valid && s_ready;
        mv  = m_valid;
        mp  = m_pixel;
        ms  = m_sof;
        if (mv && mr && exp_q.size() > 0) begin
            if (exp_q[0].sof) begin
                mdl_clamp = exp_q[0].sat;
            end else begin
                t = mdl_clamp + exp_q[0].sat;
                mdl_clamp = (t > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : t;
            end
        end
        if (acc) begin
            if (sof) begin
                mdl_op  = int'(cfg_op);
                mdl_thr = int'(cfg_thresh);
                mdl_bri = int'($signed(cfg_bright));
            end
            exp_q.push_back(ref_beat(pix, sof, mdl_op, mdl_thr, mdl_bri));
        end
        @(posedge clk);
        #1;
    endtask

    // Send one beat with m_ready high and wait (bounded) for its output
    task automatic run_beat(input logic [23:0] pix, input logic sof,
                            output logic [23:0] got, output logic got_sof,
                            output exp_t e, output int lat);
        logic acc, mv, ms, a2;
        logic [23:0] mp;
        got     = '0;
        got_sof = 1'b0;
        lat     = -1;
        step(1'b1, pix, sof, 1'b1, acc, mv, mp, ms);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 24'h0, 1'b0, 1'b1, a2, mv, mp, ms);
            if (mv) begin
                got     = mp;
                got_sof = ms;
                lat     = acc ? i : -1;
                break;
            end
        end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{pix: 24'hx, sof: 1'bx, sat: -1};
    endtask

    task automatic reset_model();
        exp_q.delete();
        mdl_op    = 0;
        mdl_thr   = 0;
        mdl_bri   = 0;
        mdl_clamp = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_valid = 1'b0; s_pixel = '0; s_sof = 1'b0; m_ready = 1'b1;
        cfg_op = '0; cfg_thresh = '0; cfg_bright = '0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (m_valid !== 1'b0 || m_sof !== 1'b0 || m_pixel !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b sof=%b px=%h, want v=0 sof=0 px=000000",
                     m_valid, m_sof, m_pixel);
        end
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_s_ready: got %b, want 1", s_ready);
        end
`ifdef PIXPROC_CLAMP_CNT_EN
        n_cmp++;
        if (clamp_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_clamp: got %0d, want 0", clamp_cnt);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_invert();
        logic [23:0] got; logic gs; exp_t e; int lat;
        cfg_op = 3'd1; cfg_thresh = '0; cfg_bright = '0;
        run_beat(24'h123456, 1'b1, got, gs, e, lat);
        n_cmp++;
        if (got !== 24'hEDCBA9) begin
            n_bad++;
            $display("FAIL invert_pixel: got %h, want EDCBA9", got);
        end
        n_cmp++;
        if (lat != 2) begin
            n_bad++;
            $display("FAIL invert_latency: got %0d, want 2", lat);
        end
        n_cmp++;
        if (gs !== 1'b1) begin
            n_bad++;
            $display("FAIL invert_sof: got %b, want 1", gs);
        end
    endtask

    task automatic test_brightness();
        logic [23:0] got; logic gs; exp_t e; int lat;
        cfg_op = 3'd3; cfg_bright = 8'h14;
        run_beat(24'hF01080, 1'b1, got, gs, e, lat);
        n_cmp++;
        if (got !== 24'hFF2494) begin
            n_bad++;
            $display("FAIL bright_pos: got %h, want FF2494", got);
        end
`ifdef PIXPROC_CLAMP_CNT_EN
        n_cmp++;
        if (clamp_cnt !== 32'd1) begin
            n_bad++;
            $display("FAIL bright_pos_clamp: got %0d, want 1", clamp_cnt);
        end
`endif
        cfg_bright = 8'hEC;
        run_beat(24'h0AFF80, 1'b1, got, gs, e, lat);
        n_cmp++;
        if (got !== 24'h00EB6C) begin
            n_bad++;
            $display("FAIL bright_neg: got %h, want 00EB6C", got);
        end
`ifdef PIXPROC_CLAMP_CNT_EN
        n_cmp++;
        if (clamp_cnt !== 32'd1) begin
            n_bad++;
            $display("FAIL bright_neg_clamp: got %0d, want 1", clamp_cnt);
        end
`endif
    endtask

    task automatic test_thresh_gray();
        logic [23:0] got; logic gs; exp_t e; int lat;
        cfg_op = 3'd2; cfg_thresh = 8'h80;
        run_beat(24'h808100, 1'b1, got, gs, e, lat);
        n_cmp++;
        if (got !== 24'h00FF00) begin
            n_bad++;
            $display("FAIL thresh_80: got %h, want 00FF00", got);
        end
        cfg_op = 3'd4;
        run_beat(24'hFFFFFF, 1'b1, got, gs, e, lat);
        n_cmp++;
        if (got !== 24'hFFFFFF) begin
            n_bad++;
            $display("FAIL gray_white: got %h, want FFFFFF", got);
        end
        run_beat(24'h646464, 1'b0, got, gs, e, lat);
        n_cmp++;
        if (got !== 24'h646464) begin
            n_bad++;
            $display("FAIL gray_64: got %h, want 646464", got);
        end
    endtask

    task automatic test_boundaries();
        logic [23:0] got; logic gs; exp_t e; int lat;
        cfg_op = 3'd3; cfg_bright = 8'h7F;
        run_beat(24'hFFFFFF, 1'b1, got, gs, e, lat);
        n_cmp++;
        if (got !== 24'hFFFFFF) begin
            n_bad++;
            $display("FAIL bright_max_sat: got %h, want FFFFFF", got);
        end
`ifdef PIXPROC_CLAMP_CNT_EN
        n_cmp++;
        if (clamp_cnt !== 32'd3) begin
            n_bad++;
            $display("FAIL bright_max_clamp: got %0d, want 3", clamp_cnt);
        end
`endif
        cfg_bright = 8'h80;
        run_beat(24'h000000, 1'b1, got, gs, e, lat);
        n_cmp++;
        if (got !== 24'h000000) begin
            n_bad++;
            $display("FAIL bright_min_sat: got %h, want 000000", got);
        end
        run_beat(24'h81FF05, 1'b0, got, gs, e, lat);
        n_cmp++;
        if (got !== 24'h017F00) begin
            n_bad++;
            $display("FAIL bright_min_mixed: got %h, want 017F00", got);
        end
`ifdef PIXPROC_CLAMP_CNT_EN
        n_cmp++;
        if (clamp_cnt !== 32'd4) begin
            n_bad++;
            $display("FAIL bright_min_clamp: got %0d, want 4", clamp_cnt);
        end
`endif
        cfg_op = 3'd2; cfg_thresh = 8'hFF;
        run_beat(24'hFFFFFF, 1'b1, got, gs, e, lat);
        n_cmp++;
        if (got !== 24'h000000) begin
            n_bad++;
            $display("FAIL thresh_ff: got %h, want 000000", got);
        end
        cfg_op = 3'd6;
        run_beat(24'hA5C3E1, 1'b1, got, gs, e, lat);
        n_cmp++;
        if (got !== 24'hA5C3E1) begin
            n_bad++;
            $display("FAIL reserved_op: got %h, want A5C3E1", got);
        end
    endtask

    task automatic test_random_stream();
        logic acc, mv, ms, sv, mr;
        logic prev_stall;
        logic [23:0] mp, prev_mp, pix;
        logic prev_ms;
        int sent, got;
        exp_t e;
        sent = 0; got = 0; prev_stall = 1'b0; prev_mp = '0; prev_ms = 1'b0;
        cfg_op     = 3'($urandom_range(0, 7));
        cfg_thresh = 8'($urandom);
        cfg_bright = 8'($urandom);
        for (int cyc = 0; cyc < 600 && got < 16; cyc++) begin
            sv  = (sent < 16) && ($urandom_range(0, 9) < 7);
            mr  = ($urandom_range(0, 9) < 6);
            pix = 24'($urandom);
            step(sv, pix, sv && (sent == 0), mr, acc, mv, mp, ms);
            if (acc) sent++;
            if (prev_stall) begin
                n_cmp++;
                if (mv !== 1'b1 || mp !== prev_mp || ms !== prev_ms) begin
                    n_bad++;
                    $display("FAIL stall_hold: got v=%b px=%h sof=%b, want v=1 px=%h sof=%b",
                             mv, mp, ms, prev_mp, prev_ms);
                end
            end
            if (mv && mr) begin
                got++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL stream_extra: got px=%h, want no beat", mp);
                end else begin
                    e = exp_q.pop_front();
                    if (mp !== e.pix || ms !== e.sof) begin
                        n_bad++;
                        $display("FAIL stream_beat%0d: got px=%h sof=%b, want px=%h sof=%b",
                                 got, mp, ms, e.pix, e.sof);
                    end
                end
            end
            prev_stall = mv && !mr;
            prev_mp    = mp;
            prev_ms    = ms;
        end
        n_cmp++;
        if (got != 16 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL stream_count: got %0d out (%0d pending), want 16 out (0 pending)",
                     got, exp_q.size());
        end
`ifdef PIXPROC_CLAMP_CNT_EN
        n_cmp++;
        if (longint'(clamp_cnt) != mdl_clamp) begin
            n_bad++;
            $display("FAIL stream_clamp: got %0d, want %0d", clamp_cnt, mdl_clamp);
        end
`endif
        reset_model();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_midframe_cfg();
        logic [23:0] got, p0, p1, p2; logic gs; exp_t e; int lat;
        p0 = 24'($urandom); p1 = 24'($urandom); p2 = 24'($urandom);
        cfg_op = 3'd1;
        run_beat(p0, 1'b1, got, gs, e, lat);
        n_cmp++;
        if (got !== ~p0) begin
            n_bad++;
            $display("FAIL midframe_first: got %h, want %h", got, ~p0);
        end
        cfg_op = 3'd0;
        run_beat(p1, 1'b0, got, gs, e, lat);
        n_cmp++;
        if (got !== ~p1) begin
            n_bad++;
            $display("FAIL midframe_ignored: got %h, want %h", got, ~p1);
        end
        run_beat(p2, 1'b1, got, gs, e, lat);
        n_cmp++;
        if (got !== p2 || gs !== 1'b1) begin
            n_bad++;
            $display("FAIL midframe_next_sof: got %h sof=%b, want %h sof=1", got, gs, p2);
        end
    endtask

    task automatic test_reset_stall();
        logic a1, a2, acc, mv, ms; logic [23:0] mp, got, pc; logic gs; exp_t e; int lat;
        cfg_op = 3'd1;
        step(1'b1, 24'h111111, 1'b1, 1'b0, a1, mv, mp, ms);
        step(1'b1, 24'h222222, 1'b0, 1'b0, a2, mv, mp, ms);
        step(1'b0, 24'h0, 1'b0, 1'b0, acc, mv, mp, ms);
        n_cmp++;
        if (!(a1 && a2) || mv !== 1'b1 || s_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_stall_setup: got acc=%b%b v=%b rdy=%b, want acc=11 v=1 rdy=0",
                     a1, a2, mv, s_ready);
        end
        rst = 1'b1;
        step(1'b0, 24'h0, 1'b0, 1'b0, acc, mv, mp, ms);
        rst = 1'b0;
        reset_model();
        step(1'b0, 24'h0, 1'b0, 1'b1, acc, mv, mp, ms);
        n_cmp++;
        if (mv !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_stall_flush: got m_valid=%b, want 0", mv);
        end
        step(1'b0, 24'h0, 1'b0, 1'b1, acc, mv, mp, ms);
        n_cmp++;
        if (mv !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_stall_drop: got m_valid=%b, want 0", mv);
        end
        pc = 24'($urandom);
        cfg_op = 3'd1;
        run_beat(pc, 1'b0, got, gs, e, lat);
        n_cmp++;
        if (got !== pc || lat != 2) begin
            n_bad++;
            $display("FAIL rst_shadow_pass: got %h lat=%0d, want %h lat=2", got, lat, pc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_invert();
        test_brightness();
        test_thresh_gray();
        test_boundaries();
        test_random_stream();
        test_midframe_cfg();
        test_reset_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
